// File: rtl/instruction_fetch_unit.sv
// Fetch-stage controller: sequences one instruction-memory request at a time,
// steers the PC register's next-PC input, and owns the IF/ID pipeline register
// with its stall, flush and redirect behaviour.
module instruction_fetch_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_value,
    output logic [N-1:0] new_pc,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         stall,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] ifid_instr,
    output logic [N-1:0] ifid_pc_plus4,
    output logic         ifid_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t       state_q;
    logic         squash_q;
    logic [N-1:0] fetch_addr_q;
    logic         imem_req_q;
    logic [N-1:0] hold_q;
    logic [N-1:0] ifid_instr_q;
    logic [N-1:0] ifid_pc_plus4_q;
    logic         ifid_valid_q;

    logic [N-1:0] fetch_addr_plus4;
    logic         load_from_mem;
    logic         load_from_hold;
    logic         ifid_load;

    // Address increment wraps modulo 2^N; the PC register applies any masking.
    function automatic logic [N-1:0] addr_inc4(input logic [N-1:0] a);
        return a + N'(4);
    endfunction

    assign fetch_addr_plus4 = addr_inc4(fetch_addr_q);

    // Decode the cycles that write a fresh instruction into IF/ID; a redirect
    // or a squashed response always wins over a load.
    always_comb begin
        load_from_mem  = 1'b0;
        load_from_hold = 1'b0;
        if (!branch_taken && !stall) begin
            load_from_mem  = (state_q == S_WAIT) && imem_rvalid && !squash_q;
            load_from_hold = (state_q == S_HOLD);
        end
        ifid_load = load_from_mem || load_from_hold;
    end

    // The PC register has no enable, so the current PC is fed back to hold it.
    assign new_pc = !reset       ? '0 :
                    branch_taken ? branch_target :
                    ifid_load    ? fetch_addr_plus4 :
                                   pc_value;

    assign imem_req      = imem_req_q;
    assign imem_addr     = fetch_addr_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_valid    = ifid_valid_q;

    // Fetch FSM, request outputs, hold buffer and IF/ID register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            squash_q        <= 1'b0;
            fetch_addr_q    <= '0;
            imem_req_q      <= 1'b0;
            hold_q          <= '0;
            ifid_instr_q    <= '0;
            ifid_pc_plus4_q <= '0;
            ifid_valid_q    <= 1'b0;
        end else begin
            // Flush keeps pc_plus4 so only instr/valid turn into a bubble.
            if (branch_taken) begin
                ifid_instr_q <= '0;
                ifid_valid_q <= 1'b0;
            end else if (load_from_mem) begin
                ifid_instr_q    <= imem_rdata;
                ifid_pc_plus4_q <= fetch_addr_plus4;
                ifid_valid_q    <= 1'b1;
            end else if (load_from_hold) begin
                ifid_instr_q    <= hold_q;
                ifid_pc_plus4_q <= fetch_addr_plus4;
                ifid_valid_q    <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    fetch_addr_q <= branch_taken ? branch_target : pc_value;
                    state_q      <= S_REQ;
                    imem_req_q   <= 1'b1;
                end
                S_REQ: begin
                    // The request cannot be withdrawn; mark its data for dropping.
                    if (branch_taken) squash_q <= 1'b1;
                    if (imem_ready) begin
                        state_q    <= S_WAIT;
                        imem_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (branch_taken) begin
                            fetch_addr_q <= branch_target;
                            squash_q     <= 1'b0;
                            state_q      <= S_REQ;
                            imem_req_q   <= 1'b1;
                        end else if (squash_q) begin
                            // PC register already holds the redirect target.
                            fetch_addr_q <= pc_value;
                            squash_q     <= 1'b0;
                            state_q      <= S_REQ;
                            imem_req_q   <= 1'b1;
                        end else if (!stall) begin
                            fetch_addr_q <= fetch_addr_plus4;
                            state_q      <= S_REQ;
                            imem_req_q   <= 1'b1;
                        end else begin
                            hold_q  <= imem_rdata;
                            state_q <= S_HOLD;
                        end
                    end else if (branch_taken) begin
                        squash_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        hold_q       <= '0;
                        fetch_addr_q <= branch_target;
                        state_q      <= S_REQ;
                        imem_req_q   <= 1'b1;
                    end else if (!stall) begin
                        fetch_addr_q <= fetch_addr_plus4;
                        state_q      <= S_REQ;
                        imem_req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
